// File: rtl/oc8051_cxrom_fetch.sv
// oc8051_cxrom_fetch: byte prefetch queue between a combinational 32-bit code
// ROM and the 8051 core. Four bytes are fetched per cycle into a circular
// queue, and the core sees the three oldest bytes as op1..op3.
// Optional feature: define OC8051_CXROM_FETCH_STALL_CNT_EN to add a
// saturating 16-bit counter of cycles spent without a valid instruction window.
module oc8051_cxrom_fetch #(
    parameter int unsigned QDEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] cxrom_addr,
    input  logic [31:0] cxrom_data_in,
    input  logic [15:0] pc_in,
    input  logic        pc_req,
    input  logic        adv,
    input  logic [1:0]  adv_len,
    output logic [23:0] op_out,
    output logic [15:0] op_pc,
    output logic        op_valid
`ifdef OC8051_CXROM_FETCH_STALL_CNT_EN
    ,output logic [15:0] stall_cnt
`endif
);

    localparam int unsigned HW        = $clog2(QDEPTH);
    localparam int unsigned CW        = $clog2(QDEPTH) + 1;
    localparam int unsigned FETCH_B   = 4;
    localparam int unsigned WIN_B     = 3;
    localparam int unsigned APPEND_MX = QDEPTH - FETCH_B;

    // Registered state
    logic [7:0]    r_q [QDEPTH];
    logic [HW-1:0] r_head;
    logic [CW-1:0] r_count;
    logic [15:0]   r_faddr;
    logic [15:0]   r_op_pc;
    logic [23:0]   r_op_out;
    logic          r_op_valid;

    // Next-state values
    logic [7:0]    w_q_nxt [QDEPTH];
    logic [HW-1:0] w_head_nxt;
    logic [CW-1:0] w_count_nxt;
    logic [15:0]   w_faddr_nxt;
    logic [15:0]   w_op_pc_nxt;
    logic [23:0]   w_op_out_nxt;
    logic          w_op_valid_nxt;

    // Control and index helpers
    logic          w_append;
    logic          w_consume;
    logic [HW-1:0] w_tail;
    logic [HW-1:0] w_idx;
    logic [HW-1:0] w_rd0;
    logic [HW-1:0] w_rd1;
    logic [HW-1:0] w_rd2;

    // Decide whether this cycle appends a ROM word and/or consumes bytes
    always_comb begin
        w_append  = 1'b0;
        w_consume = 1'b0;
        if (!pc_req) begin
            w_append  = (r_count <= CW'(APPEND_MX));
            w_consume = adv && r_op_valid && (adv_len != 2'd0);
        end
    end

    // Tail index is taken from the pre-consumption count, so appended bytes
    // never land on live entries even when the core consumes in the same cycle
    always_comb begin
        w_tail = r_head + HW'(r_count);
    end

    // Queue contents: write the four fetched bytes at the tail
    always_comb begin
        w_q_nxt = r_q;
        w_idx   = '0;
        if (w_append) begin
            for (int k = 0; k < int'(FETCH_B); k++) begin
                w_idx          = w_tail + HW'(k);
                w_q_nxt[w_idx] = cxrom_data_in[8*k +: 8];
            end
        end
    end

    // Head, count, fetch address and op_pc; a redirect overrides everything
    always_comb begin
        w_head_nxt  = r_head;
        w_count_nxt = r_count;
        w_faddr_nxt = r_faddr;
        w_op_pc_nxt = r_op_pc;
        if (pc_req) begin
            w_head_nxt  = '0;
            w_count_nxt = '0;
            w_faddr_nxt = pc_in;
            w_op_pc_nxt = pc_in;
        end else begin
            if (w_consume) begin
                w_head_nxt  = r_head + HW'(adv_len);
                w_op_pc_nxt = r_op_pc + 16'(adv_len);
            end
            if (w_append) begin
                w_faddr_nxt = r_faddr + 16'(FETCH_B);
            end
            w_count_nxt = r_count
                        - (w_consume ? CW'(adv_len) : CW'(0))
                        + (w_append  ? CW'(FETCH_B) : CW'(0));
        end
    end

    // Instruction window is precomputed from next state so it is registered
    always_comb begin
        w_rd0          = w_head_nxt;
        w_rd1          = w_head_nxt + HW'(1);
        w_rd2          = w_head_nxt + HW'(2);
        w_op_valid_nxt = (w_count_nxt >= CW'(WIN_B));
        w_op_out_nxt   = {w_q_nxt[w_rd2], w_q_nxt[w_rd1], w_q_nxt[w_rd0]};
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(QDEPTH); i++) begin
                r_q[i] <= '0;
            end
            r_head     <= '0;
            r_count    <= '0;
            r_faddr    <= '0;
            r_op_pc    <= '0;
            r_op_out   <= '0;
            r_op_valid <= 1'b0;
        end else begin
            r_q        <= w_q_nxt;
            r_head     <= w_head_nxt;
            r_count    <= w_count_nxt;
            r_faddr    <= w_faddr_nxt;
            r_op_pc    <= w_op_pc_nxt;
            r_op_out   <= w_op_out_nxt;
            r_op_valid <= w_op_valid_nxt;
        end
    end

`ifdef OC8051_CXROM_FETCH_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Count starved cycles that are not explained by a redirect, saturating
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (!r_op_valid && !pc_req && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign cxrom_addr = r_faddr;
    assign op_pc      = r_op_pc;
    assign op_out     = r_op_out;
    assign op_valid   = r_op_valid;

endmodule

// File: tb/tb_oc8051_cxrom_fetch.sv
// Directed bench for oc8051_cxrom_fetch. ROM model: byte at address i is i[7:0].
module tb_oc8051_cxrom_fetch;

    logic        clk;
    logic        rst;
    logic [15:0] cxrom_addr;
    logic [31:0] cxrom_data_in;
    logic [15:0] pc_in;
    logic        pc_req;
    logic        adv;
    logic [1:0]  adv_len;
    logic [23:0] op_out;
    logic [15:0] op_pc;
    logic        op_valid;
`ifdef OC8051_CXROM_FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int total;
    int bad;

    oc8051_cxrom_fetch #(.QDEPTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .cxrom_addr    (cxrom_addr),
        .cxrom_data_in (cxrom_data_in),
        .pc_in         (pc_in),
        .pc_req        (pc_req),
        .adv           (adv),
        .adv_len       (adv_len),
        .op_out        (op_out),
        .op_pc         (op_pc),
        .op_valid      (op_valid)
`ifdef OC8051_CXROM_FETCH_STALL_CNT_EN
        ,.stall_cnt    (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ROM: ROM[a] = a[7:0]
    logic [15:0] a1, a2, a3;
    always_comb begin
        a1 = cxrom_addr + 16'd1;
        a2 = cxrom_addr + 16'd2;
        a3 = cxrom_addr + 16'd3;
        cxrom_data_in = {a3[7:0], a2[7:0], a1[7:0], cxrom_addr[7:0]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0; pc_req = 1'b0; pc_in = 16'h0; adv = 1'b0; adv_len = 2'd0;

        // Reset state
        step(); step();
        check("rst_valid", 32'(op_valid), 32'h0);
        check("rst_out",   32'(op_out),   32'h0);
        check("rst_addr",  32'(cxrom_addr), 32'h0);
        check("rst_pc",    32'(op_pc),    32'h0);

        // Release: one edge later the first three bytes are presented
        rst = 1'b1;
        step();
        check("rel_valid", 32'(op_valid), 32'h1);
        check("rel_out",   32'(op_out),   32'h020100);
        check("rel_pc",    32'(op_pc),    32'h0);
        check("rel_addr",  32'(cxrom_addr), 32'h4);

        // Fill without consumption: saturate at 8 bytes, fetch address holds
        step();
        check("fill_addr8", 32'(cxrom_addr), 32'h8);
        for (int i = 0; i < 8; i++) step();
        check("full_addr_hold", 32'(cxrom_addr), 32'h8);
        check("full_out",       32'(op_out),     32'h020100);

        // Stream with adv_len=3
        adv = 1'b1; adv_len = 2'd3;
        step();
        check("s1_out", 32'(op_out), 32'h050403);
        check("s1_pc",  32'(op_pc),  32'h3);
        step();
        check("s2_valid", 32'(op_valid), 32'h0);
        check("s2_pc",    32'(op_pc),    32'h6);
        step();
        check("s3_valid", 32'(op_valid), 32'h1);
        check("s3_out",   32'(op_out),   32'h080706);
        check("s3_addr",  32'(cxrom_addr), 32'hC);
        step();
        check("s4_out", 32'(op_out), 32'h0B0A09);
        step();
        check("s5_out",  32'(op_out),     32'h0E0D0C);
        check("s5_pc",   32'(op_pc),      32'hC);
        check("s5_addr", 32'(cxrom_addr), 32'h10);
        step();
        check("s6_out", 32'(op_out), 32'h11100F);
        check("s6_pc",  32'(op_pc),  32'hF);

        // Redirect to 0x1234
        adv = 1'b0; adv_len = 2'd0; pc_req = 1'b1; pc_in = 16'h1234;
        step();
        check("rd_addr",  32'(cxrom_addr), 32'h1234);
        check("rd_valid", 32'(op_valid),   32'h0);
        pc_req = 1'b0;
        step();
        check("rd_out",   32'(op_out),   32'h363534);
        check("rd_pc",    32'(op_pc),    32'h1234);
        check("rd_valid2", 32'(op_valid), 32'h1);

        // Redirect and advance together: advance is dropped
        pc_req = 1'b1; pc_in = 16'h0040; adv = 1'b1; adv_len = 2'd1;
        step();
        check("ra_valid", 32'(op_valid), 32'h0);
        check("ra_pc",    32'(op_pc),    32'h0040);
        pc_req = 1'b0;
        step();
        check("ra_valid2", 32'(op_valid), 32'h1);
        check("ra_pc2",    32'(op_pc),    32'h0040);
        check("ra_out",    32'(op_out),   32'h424140);

        // Wrap from 0xFFF8 with adv_len=1
        pc_req = 1'b1; pc_in = 16'hFFF8; adv = 1'b0; adv_len = 2'd0;
        step();
        pc_req = 1'b0; adv = 1'b1; adv_len = 2'd1;
        step();
        check("w1_out", 32'(op_out), 32'hFAF9F8);
        check("w1_pc",  32'(op_pc),  32'hFFF8);
        step();
        check("w2_addr", 32'(cxrom_addr), 32'h0000);
        check("w2_pc",   32'(op_pc),      32'hFFF9);
        step(); step(); step(); step();
        check("w6_out",  32'(op_out),     32'hFFFEFD);
        check("w6_addr", 32'(cxrom_addr), 32'h0004);
        step(); step();
        check("w8_pc",  32'(op_pc),  32'hFFFF);
        check("w8_out", 32'(op_out), 32'h0100FF);
        step();
        check("w9_pc",  32'(op_pc),  32'h0000);
        check("w9_out", 32'(op_out), 32'h020100);

        // Asynchronous reset mid-cycle discards the queue
        adv = 1'b0; adv_len = 2'd0;
        #2;
        rst = 1'b0;
        #1;
        check("ar_valid", 32'(op_valid),   32'h0);
        check("ar_addr",  32'(cxrom_addr), 32'h0);
        check("ar_out",   32'(op_out),     32'h0);
        step();
        rst = 1'b1;
        step();
        check("ar_rel_out", 32'(op_out), 32'h020100);
        check("ar_rel_pc",  32'(op_pc),  32'h0);

        // adv with adv_len=0 is ignored
        adv = 1'b1; adv_len = 2'd0;
        step();
        check("len0_pc",   32'(op_pc),      32'h0);
        check("len0_out",  32'(op_out),     32'h020100);
        check("len0_addr", 32'(cxrom_addr), 32'h8);
        adv = 1'b0;

`ifdef OC8051_CXROM_FETCH_STALL_CNT_EN
        // Stall counter: redirect cycles do not count, a starved idle cycle does
        rst = 1'b0;
        pc_req = 1'b1; pc_in = 16'h0100;
        step();
        check("sc_rst", 32'(stall_cnt), 32'h0);
        rst = 1'b1;
        step(); step(); step();
        check("sc_req3", 32'(stall_cnt), 32'h0);
        pc_req = 1'b0;
        step();
        check("sc_gap", 32'(stall_cnt), 32'h1);
        step();
        check("sc_hold", 32'(stall_cnt), 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/oc8051_cxrom_fetch.md
OC8051_CXROM_FETCH -- requirements
Module: oc8051_cxrom_fetch

Interface
REQ-001 SHALL have parameter: QDEPTH, 8, byte capacity of the prefetch queue (power of two, >= 8).
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: cxrom_addr  output  16  byte address presented to the combinational code ROM.
REQ-005 SHALL have port: cxrom_data_in  input  32  ROM bytes at addr..addr+3 in the same cycle; [7:0] is the byte at addr, [31:24] is the byte at addr+3.
REQ-006 SHALL have port: pc_in  input  16  redirect target address from the core.
REQ-007 SHALL have port: pc_req  input  1  redirect strobe; flushes the queue and loads pc_in.
REQ-008 SHALL have port: adv  input  1  core consumes adv_len bytes this cycle.
REQ-009 SHALL have port: adv_len  input  2  bytes consumed (1..3); 0 means no consumption.
REQ-010 SHALL have port: op_out  output  24  op1 in [7:0], op2 in [15:8], op3 in [23:16], the three oldest queued bytes.
REQ-011 SHALL have port: op_pc  output  16  address of op1.
REQ-012 SHALL have port: op_valid  output  1  high when count >= 3.

Function
REQ-013 SHALL keep the following state: a QDEPTH-byte circular queue; a head index; a byte count of 0..QDEPTH; a 16-bit fetch address faddr; and a 16-bit op_pc.
REQ-014 SHALL drive cxrom_addr = faddr continuously, as a registered value.
REQ-015 SHALL append all 4 bytes of cxrom_data_in at the tail and add 4 to faddr (mod 2^16) when the pre-consumption count <= QDEPTH-4 and pc_req is low.
REQ-016 SHALL remove adv_len bytes from the head and add adv_len to op_pc (mod 2^16) when adv=1, op_valid=1 and pc_req=0.
REQ-017 SHALL ignore adv while op_valid=0, and SHALL ignore adv with adv_len=0.
REQ-018 SHALL, on a cycle with both append and consume, set next count = count - adv_len + 4 in that single cycle.
REQ-019 SHALL, on pc_req=1, take priority over append and consume: set count <= 0, faddr <= pc_in, op_pc <= pc_in, head <= 0.
REQ-020 SHALL give this redirect latency: if pc_req is sampled at edge N, then cxrom_addr = pc_in after edge N, and op_valid = 1 with op_out = bytes pc_in..pc_in+2 after edge N+1.
REQ-021 SHALL never overflow: with the queue full and no consumption, it does not append and holds faddr.
REQ-022 SHALL derive op_out from queue entries head, head+1 and head+2 (mod QDEPTH); the value is don't-care while op_valid=0.
REQ-023 SHALL let faddr and op_pc wrap from 0xFFFF to 0x0000 without a stall; ROM contents across the wrap are the ROM's responsibility.

Reset
REQ-024 SHALL, while rst=0 and independent of clk, force count, head, faddr, op_pc and all queue bytes to 0, giving op_valid=0 and op_out=0.
REQ-025 SHALL, when reset is asserted mid-fill, lose all queued data; after release, fetching resumes from address 0x0000.

Configuration
REQ-026 SHALL, with OC8051_CXROM_FETCH_STALL_CNT_EN defined, add output stall_cnt (16 bits) that increments on each cycle with op_valid=0 and pc_req=0, saturates at 0xFFFF, and is cleared only by reset.
REQ-027 SHALL, without OC8051_CXROM_FETCH_STALL_CNT_EN, omit the stall_cnt port and counter entirely; all other behaviour is identical.

Verification
REQ-028 SHALL cover: reset release, no pc_req, ROM[i]=i[7:0] -> after 1 edge op_valid=1, op_out=0x020100, op_pc=0x0000.
REQ-029 SHALL cover: pc_req with pc_in=0x1234 -> next cycle cxrom_addr=0x1234; following cycle op_out=0x363534, op_pc=0x1234.
REQ-030 SHALL cover: no adv for 10 cycles -> count saturates at 8, cxrom_addr holds at 0x0008, no data lost; then adv_len=3 sequence streams bytes 0x00,0x01,... in order.
REQ-031 SHALL cover: adv_len=1 every cycle from address 0xFFF8 -> op_pc wraps 0xFFFF->0x0000 and cxrom_addr wraps to 0x0000 seamlessly.
REQ-032 SHALL cover: pc_req and adv=1 in the same cycle -> adv ignored, queue flushed, op_valid=0 for exactly one cycle.
REQ-033 SHALL cover, with the macro defined: 3 pc_req pulses in consecutive cycles -> stall_cnt stays 0; one idle redirect gap -> stall_cnt=1.
